// File: rtl/pipeline_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package pipeline_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 10;

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/pipeline_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // shifted < 2*divisor, so the WIDTH+1 bit difference never wraps and its MSB is the borrow.
  assign shifted = {rem_in, din};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/pipeline_div.sv
// Iterative unsigned divider: one quotient bit per cycle, valid/ready result hand-off.
// Handshake: a request is taken on an edge with start=1 and in_ready=1; a result is consumed on an edge with valid=1 and out_ready=1.
module pipeline_div
  import pipeline_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero,
  output state_t           state_dbg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opf;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .din     (opf[WIDTH-1]),
    .divisor (opd),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (d == '0) ? DONE : RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opf      <= '0;
      opd      <= '0;
      rem      <= '0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (d == '0) begin
              q        <= '1;
              r        <= f;
              div_zero <= 1'b1;
            end else begin
              opf <= f;
              opd <= d;
              rem <= '0;
              cnt <= '0;
            end
          end
        end
        RUN: begin
          opf <= {opf[WIDTH-2:0], step_q};
          rem <= step_rem;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            q        <= {opf[WIDTH-2:0], step_q};
            r        <= step_rem;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign valid     = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_div.sv
// Self-checking bench for pipeline_div: directed scenarios plus a randomized scoreboard run.
module tb_pipeline_div;
  import pipeline_div_pkg::*;

  localparam int W = 10;
  localparam int LIMIT = 4 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] f = '0;
  logic [W-1:0] d = '0;
  logic         in_ready, busy, valid, div_zero;
  logic [W-1:0] q, r;
  state_t       state_dbg;

  int checks = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];

  pipeline_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .f         (f),
    .d         (d),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .busy      (busy),
    .valid     (valid),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Expected result packed as {q, r, div_zero}.
  function automatic logic [2*W:0] model(input logic [W-1:0] fv, input logic [W-1:0] dv);
    logic [W-1:0] ones;
    ones = '1;
    if (dv == '0) return {ones, fv, 1'b1};
    return {fv / dv, fv % dv, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] fv, input logic [W-1:0] dv);
    int n;
    n = 0;
    while (!in_ready && n < LIMIT) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%0b required=1", in_ready);
    end
    f = fv; d = dv; start = 1'b1;
    tick();
    start = 1'b0;
    f = W'($urandom);
    d = W'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < LIMIT) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({q, r, div_zero, valid, busy, in_ready} !== {{(2*W){1'b0}}, 4'b0001}) begin
      failures++;
      $display("FAIL reset_state q=%0d r=%0d dz=%0b v=%0b b=%0b ir=%0b required 0 0 0 0 0 1",
               q, r, div_zero, valid, busy, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [2*W:0] e;
    accept(10'd100, 10'd7);
    exp_q.push_back(model(10'd100, 10'd7));
    wait_valid(lat);
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL basic_latency edges=%0d required=%0d", lat, W);
    end
    e = exp_q.pop_front();
    checks++;
    if ({q, r, div_zero} !== e) begin
      failures++;
      $display("FAIL basic_result q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
               q, r, div_zero, e[2*W:W+1], e[W:1], e[0]);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if ({valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL basic_release valid=%0b in_ready=%0b required 0 1", valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic [2*W:0] e;
    accept(10'd1023, 10'd1);
    exp_q.push_back(model(10'd1023, 10'd1));
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if ({q, r, div_zero} !== e) begin
      failures++;
      $display("FAIL extreme_max q=%0d r=%0d required q=%0d r=%0d", q, r, e[2*W:W+1], e[W:1]);
    end
    out_ready = 1'b1; tick();
    // out_ready stays high through the whole next RUN and must not cut it short.
    accept(10'd5, 10'd1023);
    exp_q.push_back(model(10'd5, 10'd1023));
    wait_valid(lat);
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL extreme_ready_in_run edges=%0d required=%0d", lat, W);
    end
    e = exp_q.pop_front();
    checks++;
    if ({q, r, div_zero} !== e) begin
      failures++;
      $display("FAIL extreme_min q=%0d r=%0d required q=%0d r=%0d", q, r, e[2*W:W+1], e[W:1]);
    end
    tick(); out_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    logic [2*W:0] e;
    accept(10'd300, 10'd0);
    exp_q.push_back(model(10'd300, 10'd0));
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL dz_latency valid=%0b required=1 at first edge after accept", valid);
    end
    e = exp_q.pop_front();
    checks++;
    if ({q, r, div_zero} !== e) begin
      failures++;
      $display("FAIL dz_result q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
               q, r, div_zero, e[2*W:W+1], e[W:1], e[0]);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [2*W:0] e;
    accept(10'd200, 10'd7);
    exp_q.push_back(model(10'd200, 10'd7));
    tick(); tick();
    f = 10'd9; d = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL start_in_run busy=%0b in_ready=%0b required 1 0", busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== W - 3) begin
      failures++;
      $display("FAIL bp_latency edges=%0d required=%0d", lat, W - 3);
    end
    e = exp_q[0];
    f = 10'd9; d = 10'd3; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({q, r, div_zero, valid} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d q=%0d r=%0d valid=%0b required q=%0d r=%0d valid=1",
                 i, q, r, valid, e[2*W:W+1], e[W:1]);
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if ({q, r, div_zero, in_ready} !== {e, 1'b1}) begin
      failures++;
      $display("FAIL bp_retain q=%0d r=%0d in_ready=%0b required q=%0d r=%0d in_ready=1",
               q, r, in_ready, e[2*W:W+1], e[W:1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2*W:0] e;
    accept(10'd500, 10'd9);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q, r, div_zero, valid, busy, in_ready} !== {{(2*W){1'b0}}, 4'b0001}) begin
      failures++;
      $display("FAIL reset_mid q=%0d r=%0d dz=%0b v=%0b b=%0b ir=%0b required 0 0 0 0 0 1",
               q, r, div_zero, valid, busy, in_ready);
    end
    tick();
    rst_n = 1'b1;
    accept(10'd500, 10'd9);
    exp_q.push_back(model(10'd500, 10'd9));
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if ({q, r, div_zero} !== e || lat !== W) begin
      failures++;
      $display("FAIL reset_mid_redo q=%0d r=%0d edges=%0d required q=%0d r=%0d edges=%0d",
               q, r, lat, e[2*W:W+1], e[W:1], W);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, gap, exp_lat;
    logic [W-1:0] fv, dv;
    logic [2*W:0] e;
    for (int i = 0; i < 1000; i++) begin
      fv = W'($urandom_range(0, 1023));
      case ($urandom_range(0, 9))
        0:       dv = '0;
        1, 2:    dv = W'($urandom_range(1, 15));
        default: dv = W'($urandom_range(1, 1023));
      endcase
      accept(fv, dv);
      exp_q.push_back(model(fv, dv));
      wait_valid(lat);
      exp_lat = (dv == '0) ? 0 : W;
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL rand_latency i=%0d edges=%0d required=%0d", i, lat, exp_lat);
      end
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      e = exp_q.pop_front();
      checks++;
      if ({q, r, div_zero} !== e) begin
        failures++;
        $display("FAIL rand_result i=%0d f=%0d d=%0d q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                 i, fv, dv, q, r, div_zero, e[2*W:W+1], e[W:1], e[0]);
      end
      if (dv != '0) begin
        checks++;
        if (int'(q) * int'(dv) + int'(r) != int'(fv) || r >= dv) begin
          failures++;
          $display("FAIL rand_identity i=%0d f=%0d d=%0d q=%0d r=%0d", i, fv, dv, q, r);
        end
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover entries=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
